// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle of the load/store unit: request, response and word-memory port.
interface load_store_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned DATA_WIDTH = 32;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rstrb;
    logic [3:0]            mem_wmask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Environment side: core issuing requests plus the memory returning read data.
    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_addr, mem_rstrb, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane alignment, sign/zero extension, misalignment and
// illegal-width detection, single outstanding request, one-cycle response pulse.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    load_store_unit_if.slave bus
);
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t state_q, state_n;

    logic [1:0] addr_lo_q;
    logic [2:0] funct3_q;
    logic       is_store_q;

    logic                  req_ready_q, req_ready_n;
    logic                  rsp_valid_q, rsp_valid_n;
    logic                  rsp_error_q, rsp_error_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_n;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_n;
    logic                  mem_rstrb_q, mem_rstrb_n;
    logic [3:0]            mem_wmask_q, mem_wmask_n;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_n;

    logic                  req_err_c;
    logic [3:0]            st_mask_c;
    logic [DATA_WIDTH-1:0] st_data_c;
    logic [DATA_WIDTH-1:0] ld_data_c;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rstrb = mem_rstrb_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Classify the incoming request: unsupported width or (optionally) misaligned address.
    always_comb begin
        logic width_ok;
        logic misaligned;
        if (bus.req_is_store) begin
            width_ok = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                       (bus.req_funct3 == F3_W);
        end else begin
            width_ok = (bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H) ||
                       (bus.req_funct3 == F3_W) || (bus.req_funct3 == F3_BU) ||
                       (bus.req_funct3 == F3_HU);
        end
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_err_c  = !width_ok || (CHECK_ALIGN && misaligned);
    end

    // Store lane mask and replicated data for the incoming request.
    always_comb begin
        st_mask_c = 4'b1111;
        st_data_c = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_mask_c = 4'b0001 << bus.req_addr[1:0];
                st_data_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask_c = 4'b0011 << {bus.req_addr[1], 1'b0};
                st_data_c = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                st_mask_c = 4'b1111;
                st_data_c = bus.req_wdata;
            end
        endcase
    end

    // Lane extraction and extension of the returned memory word.
    always_comb begin
        logic [7:0]  lb;
        logic [15:0] lh;
        case (addr_lo_q)
            2'd0:    lb = bus.mem_rdata[7:0];
            2'd1:    lb = bus.mem_rdata[15:8];
            2'd2:    lb = bus.mem_rdata[23:16];
            default: lb = bus.mem_rdata[31:24];
        endcase
        lh = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            F3_B:    ld_data_c = {{24{lb[7]}}, lb};
            F3_H:    ld_data_c = {{16{lh[15]}}, lh};
            F3_W:    ld_data_c = bus.mem_rdata;
            F3_BU:   ld_data_c = {24'd0, lb};
            F3_HU:   ld_data_c = {16'd0, lh};
            default: ld_data_c = '0;
        endcase
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n     = state_q;
        req_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_error_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        mem_addr_n  = '0;
        mem_rstrb_n = 1'b0;
        mem_wmask_n = 4'b0000;
        mem_wdata_n = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err_c) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_error_n = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        state_n    = ACCESS;
                        mem_addr_n = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (bus.req_is_store) begin
                            mem_wmask_n = st_mask_c;
                            mem_wdata_n = st_data_c;
                        end else begin
                            mem_rstrb_n = 1'b1;
                        end
                    end
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            ACCESS: begin
                if (is_store_q) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = ld_data_c;
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_rstrb_q <= 1'b0;
            mem_wmask_q <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_n;
            req_ready_q <= req_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_error_q <= rsp_error_n;
            rsp_rdata_q <= rsp_rdata_n;
            mem_addr_q  <= mem_addr_n;
            mem_rstrb_q <= mem_rstrb_n;
            mem_wmask_q <= mem_wmask_n;
            mem_wdata_q <= mem_wdata_n;
        end
    end

    // Capture the request fields needed after acceptance.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
        end else if (state_q == IDLE && bus.req_valid) begin
            addr_lo_q  <= bus.req_addr[1:0];
            funct3_q   <= bus.req_funct3;
            is_store_q <= bus.req_is_store;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous-read word memory model.
module tb_load_store_unit;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:1023];

    always #5 CLK = ~CLK;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Memory model: read data appears on the posedge after the strobe; masked byte writes.
    always @(posedge CLK) begin
        if (RESET) begin
            bus.mem_rdata <= 32'd0;
        end else begin
            if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[11:2]];
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_wmask[i]) mem[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request from IDLE and observe six cycles after the accepting edge.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [31:0] exp_maddr, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata);
        int lat;
        int nrsp;
        int nrd;
        int nwr;
        logic [31:0] rd;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  msk;
        logic        err;
        lat = 0; nrsp = 0; nrd = 0; nwr = 0;
        rd = 32'd0; maddr = 32'd0; mwd = 32'd0; msk = 4'd0; err = 1'b0;
        check({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.rsp_valid) begin
                nrsp++;
                if (lat == 0) lat = c;
                rd  = bus.rsp_rdata;
                err = bus.rsp_error;
            end
            if (bus.mem_rstrb) begin
                nrd++;
                maddr = bus.mem_addr;
            end
            if (bus.mem_wmask != 4'd0) begin
                nwr++;
                maddr = bus.mem_addr;
                msk   = bus.mem_wmask;
                mwd   = bus.mem_wdata;
            end
            if (c < 6) step();
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/rsp_count"}, 32'(nrsp), 32'd1);
        check({tag, "/rdata"}, rd, exp_rdata);
        check({tag, "/error"}, 32'(err), 32'(exp_err));
        check({tag, "/rstrb_cycles"}, 32'(nrd), 32'((!st && !exp_err) ? 1 : 0));
        check({tag, "/wmask_cycles"}, 32'(nwr), 32'((st && !exp_err) ? 1 : 0));
        if (!exp_err) check({tag, "/mem_addr"}, maddr, exp_maddr);
        if (st && !exp_err) begin
            check({tag, "/wmask"}, 32'(msk), 32'(exp_mask));
            check({tag, "/wdata"}, mwd, exp_wdata);
        end
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h8899AABB;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst/ready", 32'(bus.req_ready), 32'd1);
        check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst/rsp_error", 32'(bus.rsp_error), 32'd0);
        check("rst/rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst/mem_addr", bus.mem_addr, 32'd0);
        check("rst/rstrb", 32'(bus.mem_rstrb), 32'd0);
        check("rst/wmask", 32'(bus.mem_wmask), 32'd0);
        check("rst/wdata", bus.mem_wdata, 32'd0);
        RESET = 1'b0;
        step();

        // Loads
        do_req("lw",  1'b0, 3'd2, 32'h100, 32'd0, 3, 32'h8899AABB, 1'b0, 32'h100, 4'd0, 32'd0);
        do_req("lb",  1'b0, 3'd0, 32'h101, 32'd0, 3, 32'hFFFFFFAA, 1'b0, 32'h100, 4'd0, 32'd0);
        do_req("lbu", 1'b0, 3'd4, 32'h103, 32'd0, 3, 32'h00000088, 1'b0, 32'h100, 4'd0, 32'd0);
        do_req("lh",  1'b0, 3'd1, 32'h102, 32'd0, 3, 32'hFFFF8899, 1'b0, 32'h100, 4'd0, 32'd0);
        do_req("lhu", 1'b0, 3'd5, 32'h100, 32'd0, 3, 32'h0000AABB, 1'b0, 32'h100, 4'd0, 32'd0);

        // Stores and read-back
        do_req("sb", 1'b1, 3'd0, 32'h206, 32'h123456EF, 2, 32'd0, 1'b0, 32'h204, 4'b0100, 32'hEFEFEFEF);
        do_req("sh", 1'b1, 3'd1, 32'h206, 32'h123456EF, 2, 32'd0, 1'b0, 32'h204, 4'b1100, 32'h56EF56EF);
        do_req("lw_after_sh", 1'b0, 3'd2, 32'h204, 32'd0, 3, 32'h56EF0000, 1'b0, 32'h204, 4'd0, 32'd0);
        do_req("sw", 1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 2, 32'd0, 1'b0, 32'h204, 4'b1111, 32'hCAFEF00D);
        do_req("lw_after_sw", 1'b0, 3'd2, 32'h204, 32'd0, 3, 32'hCAFEF00D, 1'b0, 32'h204, 4'd0, 32'd0);

        // Misaligned and illegal widths
        do_req("lw_misalign", 1'b0, 3'd2, 32'h102, 32'd0, 1, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        do_req("sh_misalign", 1'b1, 3'd1, 32'h301, 32'h1234, 1, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        do_req("ld_f3_3",     1'b0, 3'd3, 32'h100, 32'd0, 1, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        do_req("st_f3_4",     1'b1, 3'd4, 32'h100, 32'h55, 1, 32'd0, 1'b1, 32'd0, 4'd0, 32'd0);
        do_req("lhu_ok",      1'b0, 3'd5, 32'h102, 32'd0, 3, 32'h00008899, 1'b0, 32'h100, 4'd0, 32'd0);

        // Back-to-back with req_valid held high
        check("b2b/ready0", 32'(bus.req_ready), 32'd1);
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd2;
        bus.req_addr     = 32'h100;
        bus.req_valid    = 1'b1;
        step();
        bus.req_funct3 = 3'd4;
        bus.req_addr   = 32'h103;
        pulses = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) bus.req_valid = 1'b0;
            if (bus.rsp_valid) pulses++;
            if (c <= 4) check($sformatf("b2b/ready_c%0d", c), 32'(bus.req_ready), 32'((c == 4) ? 1 : 0));
            if (c == 3) begin
                check("b2b/rsp1_valid", 32'(bus.rsp_valid), 32'd1);
                check("b2b/rsp1_rdata", bus.rsp_rdata, 32'h8899AABB);
            end
            if (c == 7) begin
                check("b2b/rsp2_valid", 32'(bus.rsp_valid), 32'd1);
                check("b2b/rsp2_rdata", bus.rsp_rdata, 32'h00000088);
            end
            step();
        end
        check("b2b/pulses", 32'(pulses), 32'd2);

        // Reset while a load is in WAIT
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h100;
        bus.req_valid  = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        RESET = 1'b1;
        #1;
        check("rst_wait/ready", 32'(bus.req_ready), 32'd1);
        check("rst_wait/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_wait/rstrb", 32'(bus.mem_rstrb), 32'd0);
        step();
        RESET = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.rsp_valid) pulses++;
            step();
        end
        check("rst_wait/no_rsp", 32'(pulses), 32'd0);
        do_req("lw_post_rst", 1'b0, 3'd2, 32'h100, 32'd0, 3, 32'h8899AABB, 1'b0, 32'h100, 4'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the multicycle RV32I core's execute stage and the synchronous-read word memory.
- Accepts one load/store request at a time and performs RV32I byte-lane alignment: LB/LH/LW/LBU/LHU extraction with sign or zero extension, and SB/SH/SW write-mask and data replication.
- Detects misaligned or illegal-width accesses and reports them without touching memory.
- Returns the result as a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_addr.
- CHECK_ALIGN, 1, 1 = flag misaligned accesses; 0 = ignore low address bits (force natural alignment).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_WIDTH  byte address (rs1+imm).
- req_wdata  in  32  store data (rs2).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned/illegal access; valid with rsp_valid.
- mem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits always 0.
- mem_rstrb  out  1  read strobe; memory returns mem_rdata on the following posedge.
- mem_wmask  out  4  byte write enables; bit i = bits [8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word, sync read, 1-cycle latency.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Reset value is IDLE.
- While RESET is high, every output is 0 except req_ready.
- req_ready = 1 in IDLE only.
- IDLE, on req_valid: latch addr, funct3, wdata, is_store, then check the access.
  - Error if funct3 is not in {0,1,2,4,5} for loads, or not in {0,1,2} for stores.
  - With CHECK_ALIGN=1, also error if a halfword has addr[0]=1 or a word has addr[1:0]!=0.
  - Error -> RESP with rsp_error=1; no mem_rstrb or mem_wmask is ever asserted.
  - Otherwise -> ACCESS.
- ACCESS, driven for exactly one cycle: mem_addr = {addr[AW-1:2],2'b00}.
  - Load: mem_rstrb=1, next state WAIT.
  - Store: mem_wmask/mem_wdata valid, next state RESP.
- Store lanes:
  - SB: mask = 4'b0001 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011 << (2*addr[1]), data = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111, data = wdata.
- WAIT: register the extracted load value into rsp_rdata, next state RESP.
  - Byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (16*addr[1]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- RESP: rsp_valid=1 for one cycle, next state IDLE. There is no backpressure; the core must sample rsp_valid.
- Latency, counted as cycles from the accepting edge to the rsp_valid cycle:
  - Load: 3.
  - Store: 2.
  - Error: 1.
  - Back-to-back requests: a new request is accepted the cycle after RESP.
- Outside ACCESS: mem_rstrb=0, mem_wmask=0.
- Outside RESP: rsp_valid=0, rsp_error=0. rsp_rdata holds its last value.
- With CHECK_ALIGN=0, lane selection uses only the naturally aligned bits (half uses addr[1]; word ignores addr[1:0]).
- req_valid while not in IDLE is ignored; the request is not latched.
- RESET asserted mid-operation: immediate return to IDLE with strobes and masks cleared. A partially issued load produces no response.

Test Plan:
- Load LW: mem word 0x8899AABB at 0x100; request load funct3=2 addr=0x100 -> mem_rstrb in ACCESS with mem_addr=0x100; 3 cycles later rsp_valid=1, rsp_rdata=0x8899AABB, rsp_error=0.
- Loads from word 0x8899AABB at 0x100:
  - LB addr=0x101 -> 0xFFFFFFAA.
  - LBU addr=0x103 -> 0x00000088.
  - LH addr=0x102 -> 0xFFFF8899.
  - LHU addr=0x100 -> 0x0000AABB.
- Stores, checked in the ACCESS cycle, with a 2-cycle response and rsp_rdata=0:
  - SB wdata=0x123456EF addr=0x206 -> mem_addr=0x204, wmask=4'b0100, wdata=0xEFEFEFEF.
  - SH addr=0x206 -> wmask=4'b1100, wdata=0x56EF56EF.
  - SW addr=0x204 -> wmask=4'b1111.
- Misalignment and illegal width, each responding 1 cycle after accept with mem_rstrb and mem_wmask never asserted:
  - LW addr=0x102 -> rsp_error=1.
  - SH addr=0x301 -> rsp_error=1.
  - Load funct3=3 -> rsp_error=1.
- Handshake: hold req_valid high with two queued loads -> req_ready low for ACCESS/WAIT/RESP; the second request is accepted only in the following IDLE cycle; exactly two rsp_valid pulses.
- Reset in WAIT of a load -> state IDLE, req_ready=1, rsp_valid never pulses; a subsequent LW completes normally.
